// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display driver: segment bit
// positions, glyph patterns and the BCD-to-segment lookup function.
package seg7_pkg;

   // Segment bus bit positions, bus order is {a,b,c,d,e,f,g}
   localparam int SEG_W = 7;
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   // Width of one packed BCD digit
   localparam int BCD_W = 4;

   // Largest valid BCD code; anything above shows a dash and raises err
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   // Glyph patterns, 1 = segment lit (active-high, before polarity)
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Map a BCD code to its glyph; codes 10..15 render as a dash
   function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
      logic [SEG_W-1:0] pat;
      case (bcd)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

   // True when a BCD code is outside 0..9
   function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
      return (bcd > BCD_MAX);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment lookup for the currently scanned digit.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [SEG_W-1:0] seg
);

   // Pure table lookup, shared with any other user of the package
   assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver. Latches a packed BCD word
// on load, scans one digit per PRESCALE cycles, applies leading-zero
// blanking and decimal points, and registers all pin-facing outputs with
// optional active-low polarity.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int PRESCALE   = 1000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] din,
   input  logic [DIGITS-1:0]       dp_in,
   input  logic                    blank_lz,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [DIGITS-1:0]       an,
   output logic                    err
);

   // A single-digit display still needs a 1-bit index register
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(PRESCALE);

   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

   // Polarity masks XORed in at the output registers only
   localparam logic [SEG_W-1:0]  SEG_INV = {SEG_W{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{ACTIVE_LOW}};

   // Scan timing
   logic [PW-1:0] pcnt;
   logic [IW-1:0] idx;
   logic          slot_end;

   // Latched display contents
   logic [DIGITS-1:0][BCD_W-1:0] val;
   logic [DIGITS-1:0]            dpl;

   // Per-digit derived state
   logic [DIGITS-1:0] blank_mask;
   logic              upper_zero;
   logic              any_invalid;

   // Selected digit and next output values (active-high)
   logic [BCD_W-1:0]  cur_bcd;
   logic              cur_dp;
   logic              cur_blank;
   logic [SEG_W-1:0]  cur_seg;
   logic [SEG_W-1:0]  seg_n;
   logic              dp_n;
   logic [DIGITS-1:0] an_n;

   assign slot_end = (pcnt == PCNT_LAST);

   // Prescaler and digit index; index steps on the prescaler terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or block order.
      if (!rst_n) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (slot_end) begin
         pcnt <= '0;
         idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Value and decimal-point latch; independent of the scan position
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: these latch registers are few and must read as blank after
      // reset, so they are reset; a large storage array would not be.
      if (!rst_n) begin
         val <= '0;
         dpl <= '0;
      end else if (load) begin
         val <= din;
         dpl <= dp_in;
      end
   end

   // Leading-zero mask: walk down from the top digit while all seen are zero
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      blank_mask = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         upper_zero    = upper_zero & (val[i] == '0);
         blank_mask[i] = blank_lz & upper_zero;
      end
   end

   // Flag any latched digit outside the BCD range
   always_comb begin
      any_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         any_invalid = any_invalid | bcd_invalid(val[i]);
      end
   end

   // Select the digit under the scan index
   always_comb begin
      cur_bcd   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_bcd   = val[i];
            cur_dp    = dpl[i];
            cur_blank = blank_mask[i];
         end
      end
   end

   seg7_decode u_decode (
      .bcd (cur_bcd),
      .seg (cur_seg)
   );

   // Next active-high outputs; a blanked digit drives nothing at all
   always_comb begin
      seg_n = SEG_BLANK;
      dp_n  = 1'b0;
      an_n  = '0;
      if (!cur_blank) begin
         seg_n = cur_seg;
         dp_n  = cur_dp;
         an_n  = DIGITS'(1) << idx;
      end
   end

   // Output registers with polarity applied; reset drives everything inactive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_INV;
         dp  <= ACTIVE_LOW;
         an  <= AN_INV;
         err <= 1'b0;
      end else begin
         seg <= seg_n ^ SEG_INV;
         dp  <= dp_n ^ ACTIVE_LOW;
         an  <= an_n ^ AN_INV;
         err <= any_invalid;
      end
   end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: reset, scan order and slot length,
// leading-zero blanking, invalid codes, load at a slot boundary and
// active-low polarity (second instance sharing all inputs).
module tb_seg7_mux_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic        blank_lz;

   logic [6:0]  seg,    seg_al;
   logic        dp,     dp_al;
   logic [3:0]  an,     an_al;
   logic        err,    err_al;

   int n_vec = 0;
   int n_err = 0;

   seg7_mux_driver #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .din      (din),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .seg      (seg),
      .dp       (dp),
      .an       (an),
      .err      (err)
   );

   seg7_mux_driver #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .din      (din),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .seg      (seg_al),
      .dp       (dp_al),
      .an       (an_al),
      .err      (err_al)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
      chk({tag, ".an"},  16'(an),  16'(e_an));
      chk({tag, ".seg"}, 16'(seg), 16'(e_seg));
      chk({tag, ".dp"},  16'(dp),  16'(e_dp));
   endtask

   // Advance one active edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      din      = 16'h0000;
      dp_in    = 4'b0000;
      blank_lz = 1'b0;

      // Reset state of both polarities
      #12;
      chk_out("rst", 4'b0000, 7'b0000000, 1'b0);
      chk("rst.err",    16'(err),    16'h0);
      chk("rst_al.seg", 16'(seg_al), 16'h7F);
      chk("rst_al.an",  16'(an_al),  16'hF);
      chk("rst_al.dp",  16'(dp_al),  16'h1);

      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First edge after release drives digit 0 (value 0)
      tick();
      chk_out("first", 4'b0001, 7'b1111110, 1'b0);
      chk("first_al.an",  16'(an_al),  16'hE);
      chk("first_al.seg", 16'(seg_al), 16'h01);

      // Scan 1234 with dp on digit 2
      dp_in = 4'b0100;
      din   = 16'h1234;
      load  = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk_out("scan_d0",     4'b0001, 7'b0110011, 1'b0);
      tick();
      chk_out("scan_d0_end", 4'b0001, 7'b0110011, 1'b0);
      tick();
      chk_out("scan_d1",     4'b0010, 7'b1111001, 1'b0);
      ticks(3);
      chk_out("scan_d1_end", 4'b0010, 7'b1111001, 1'b0);
      tick();
      chk_out("scan_d2",     4'b0100, 7'b1101101, 1'b1);
      ticks(3);
      chk_out("scan_d2_end", 4'b0100, 7'b1101101, 1'b1);
      tick();
      chk_out("scan_d3",     4'b1000, 7'b0110000, 1'b0);
      ticks(3);
      chk_out("scan_d3_end", 4'b1000, 7'b0110000, 1'b0);
      tick();
      chk_out("scan_wrap",   4'b0001, 7'b0110011, 1'b0);

      // Asynchronous reset mid-scan
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 4'b0000, 7'b0000000, 1'b0);
      chk("async_rst_al.an", 16'(an_al), 16'hF);
      #2;
      rst_n = 1'b1;
      tick();
      chk_out("rerelease", 4'b0001, 7'b1111110, 1'b0);

      // Leading-zero blanking of 0070
      din      = 16'h0070;
      blank_lz = 1'b1;
      load     = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk_out("blz_d0", 4'b0001, 7'b1111110, 1'b0);
      ticks(2);
      chk_out("blz_d1", 4'b0010, 7'b1110000, 1'b0);
      ticks(4);
      chk_out("blz_d2", 4'b0000, 7'b0000000, 1'b0);
      ticks(4);
      chk_out("blz_d3", 4'b0000, 7'b0000000, 1'b0);
      ticks(4);
      chk_out("blz_wrap", 4'b0001, 7'b1111110, 1'b0);

      // Same value with blanking off: all digits lit
      blank_lz = 1'b0;
      ticks(8);
      chk_out("noblz_d2", 4'b0100, 7'b1111110, 1'b1);
      ticks(4);
      chk_out("noblz_d3", 4'b1000, 7'b1111110, 1'b0);

      // Invalid code A in digit 1
      din  = 16'h00A5;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("inv_capture.err", 16'(err), 16'h0);
      tick();
      chk("inv_out.err", 16'(err), 16'h1);
      ticks(2);
      chk_out("inv_d0", 4'b0001, 7'b1011011, 1'b0);
      ticks(4);
      chk_out("inv_d1", 4'b0010, 7'b0000001, 1'b0);

      // Valid reload clears err two edges later
      din  = 16'h0005;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("valid_capture.err", 16'(err), 16'h1);
      tick();
      chk("valid_out.err", 16'(err), 16'h0);

      // Load on the terminal-count edge of slot 1
      din  = 16'h0900;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_out("tc_old", 4'b0010, 7'b1111110, 1'b0);
      tick();
      chk_out("tc_new", 4'b0100, 7'b1111011, 1'b1);
      ticks(3);
      chk_out("tc_new_end", 4'b0100, 7'b1111011, 1'b1);
      tick();
      chk_out("tc_next", 4'b1000, 7'b1111110, 1'b0);

      // Active-low digit 0 showing 8
      din  = 16'h0008;
      load = 1'b1;
      tick();
      load = 1'b0;
      ticks(3);
      chk_out("eight", 4'b0001, 7'b1111111, 1'b0);
      chk("eight_al.seg", 16'(seg_al), 16'h00);
      chk("eight_al.an",  16'(an_al),  16'hE);
      chk("eight_al.dp",  16'(dp_al),  16'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Time-multiplexed N-digit seven-segment display driver. Latches a packed BCD value on a load strobe, then scans the digits one at a time at a programmable refresh rate, driving the shared segment bus and one-hot digit enables. Adds invalid-code flagging, leading-zero blanking, per-digit decimal points and output polarity selection. Sits between the numeric datapath and the board-level display pins.

## Interface
- DIGITS, 4: number of digits scanned (≥1).
- PRESCALE, 1000: clock cycles per digit slot (≥2).
- ACTIVE_LOW, 0: 1 inverts `seg`, `dp` and `an` at the output registers.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  latch `din`/`dp_in` on this edge.
- din  in  4*DIGITS  packed BCD; digit 0 = din[3:0] = least significant.
- dp_in  in  DIGITS  decimal point per digit.
- blank_lz  in  1  enable leading-zero blanking (sampled live).
- seg  out  7  segments {a,b,c,d,e,f,g}, 1 = lit before polarity.
- dp  out  1  decimal point of the active digit.
- an  out  DIGITS  one-hot digit enable.
- err  out  1  latched value contains a digit > 9.

## Operation
- Reset (async, all registers): prescale count 0, digit index 0, latched value 0, latched dp 0, err 0; seg/dp/an inactive (all 0, or all 1 when ACTIVE_LOW).
- Prescaler counts 0..PRESCALE-1 and wraps; on terminal count the index advances, DIGITS-1 wraps to 0.
- Load: on an edge with load=1, `din` and `dp_in` are captured. A load does not reset the prescaler or index.
- Decode: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10–15 display a dash (0000001), and err=1 while any latched digit is > 9.
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked if it and every higher digit are 0. Digit 0 is never blanked. A blanked digit drives an=0, seg=0, dp=0.
- Non-blanked active digit: an bit[index]=1, seg = decode, dp = latched dp[index].
- ACTIVE_LOW inverts only at the output registers. Internal logic is active-high.

## Timing
- seg/dp/an/err are registered. Each reflects the index, latched value and blank_lz one edge earlier.
- First output after reset release: the edge after the first active clock drives digit 0.
- Load-to-display latency is 2 edges: capture, then output register.
- Index change at edge T (prescaler terminal count at T) means `an` moves at T+1. Each digit is shown for exactly PRESCALE cycles.
- Load on the same edge as an index advance: both take effect. The next output uses the new index and the new value.
- load held high recaptures every edge. The last captured value wins.
- DIGITS=1: index stays 0 and an is constant 1 (after polarity).

## Structure
- Package `seg7_pkg`: segment pattern constants (digits 0–9, DASH, BLANK), bit-order localparams, and the function `bcd_to_seg(input [3:0]) -> [6:0]`.
- Sub-module `seg7_decode`: combinational BCD→segment lookup using the package function, instantiated once on the selected digit.
- Top level holds the prescaler, index counter, latch registers, blanking mask and output registers.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=4, ACTIVE_LOW=0 unless stated.
- Reset: assert rst_n=0 mid-scan -> outputs 0 immediately (async). Release, then the first output edge drives an=0001, seg=1111110.
- Scan: load din=16'h1234, dp_in=4'b0100 -> an cycles 0001,0010,0100,1000, 4 cycles each. seg sequence is 4,3,2,1 patterns, and dp=1 only when an=0100.
- Blanking: din=16'h0070, blank_lz=1 -> an=0001 shows 0, an=0010 shows 7. Slots 2 and 3 have an=0000, seg=0. With blank_lz=0, all four digits are lit.
- Invalid: din=16'h00A5 -> err=1 two edges after load, and digit 1 shows 0000001. A later load of 16'h0005 -> err=0.
- Load at the terminal-count edge: the new value appears on the next digit with no slot lengthened or shortened.
- ACTIVE_LOW=1: reset gives seg=1111111, an=1111. Digit 0 value 8 -> seg=0000000, an=1110.
